// File: rtl/power_sequencer.sv
// Three-rail power sequencer: ramps rails 0..2 in order with power-good checks,
// settles between rails, shuts down in reverse order and latches faults.
module power_sequencer #(
  parameter int unsigned STEP_DELAY = 32'd1000,
  parameter int unsigned PG_TIMEOUT = 32'd100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [2:0] i_pg,
  output logic [2:0] o_en,
  output logic       o_allGood,
  output logic       o_fault,
  output logic [1:0] o_faultRail,
  output logic       o_busy
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned RAILS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_SETTLE,
    S_ON,
    S_SHUTDOWN,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RAILS-1:0] en_q, en_d;
  logic             fault_q, fault_d;
  logic [IDX_W-1:0] rail_q, rail_d;
  logic             busy_q, busy_d;

  logic [RAILS-1:0] below_mask, upto_mask, fail_mask;
  logic [CNT_W-1:0] cnt_inc;
  logic             step_done, pg_timeout;

  function automatic logic [IDX_W-1:0] lowest(input logic [RAILS-1:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else           lowest = 2'd2;
  endfunction

  function automatic logic [RAILS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = RAILS'(3'b001 << i);
  endfunction

  // Rails strictly below idx, and rails up to and including idx.
  always_comb begin
    below_mask = 3'b000;
    upto_mask  = 3'b001;
    case (idx_q)
      2'd1:    begin below_mask = 3'b001; upto_mask = 3'b011; end
      2'd2:    begin below_mask = 3'b011; upto_mask = 3'b111; end
      default: begin below_mask = 3'b000; upto_mask = 3'b001; end
    endcase
  end

  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign step_done  = (cnt_q == CNT_W'(STEP_DELAY - 1));
  assign pg_timeout = (cnt_q == CNT_W'(PG_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      fault_q <= 1'b0;
      rail_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      fault_q <= fault_d;
      rail_q  <= rail_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; priority on a shared edge is fault, then disable, then progress.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    fault_d   = fault_q;
    rail_d    = rail_q;
    fail_mask = '0;

    case (state_q)
      S_IDLE: begin
        en_d    = '0;
        idx_d   = '0;
        cnt_d   = '0;
        fault_d = 1'b0;
        rail_d  = '0;
        if (i_enable) begin
          state_d = S_RAMP;
          en_d    = 3'b001;
        end
      end

      S_RAMP: begin
        fail_mask = ~i_pg & below_mask;
        if (|fail_mask) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          rail_d  = lowest(fail_mask);
          cnt_d   = '0;
        end else if (!i_pg[idx_q] && pg_timeout) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          rail_d  = idx_q;
          cnt_d   = '0;
        end else if (!i_enable) begin
          state_d = S_SHUTDOWN;
          en_d    = en_q & ~onehot(idx_q);
          cnt_d   = '0;
        end else if (i_pg[idx_q]) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_SETTLE: begin
        fail_mask = ~i_pg & upto_mask;
        if (|fail_mask) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          rail_d  = lowest(fail_mask);
          cnt_d   = '0;
        end else if (!i_enable) begin
          state_d = S_SHUTDOWN;
          en_d    = en_q & ~onehot(idx_q);
          cnt_d   = '0;
        end else if (step_done) begin
          cnt_d = '0;
          if (idx_q != 2'd2) begin
            state_d = S_RAMP;
            idx_d   = IDX_W'(idx_q + 2'd1);
            en_d    = en_q | onehot(IDX_W'(idx_q + 2'd1));
          end else begin
            state_d = S_ON;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ON: begin
        en_d  = 3'b111;
        cnt_d = '0;
        if (i_pg != 3'b111) begin
          state_d = S_FAULT;
          en_d    = '0;
          fault_d = 1'b1;
          rail_d  = lowest(~i_pg);
        end else if (!i_enable) begin
          state_d = S_SHUTDOWN;
          idx_d   = 2'd2;
          en_d    = 3'b011;
        end
      end

      // Power-good is deliberately ignored here; rails drop 2,1,0.
      S_SHUTDOWN: begin
        if (step_done) begin
          cnt_d = '0;
          if (idx_q != 2'd0) begin
            idx_d = IDX_W'(idx_q - 2'd1);
            en_d  = en_q & ~onehot(IDX_W'(idx_q - 2'd1));
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_FAULT: begin
        en_d  = '0;
        cnt_d = '0;
        if (!i_enable) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          rail_d  = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_RAMP) || (state_d == S_SETTLE) || (state_d == S_SHUTDOWN);
  end

  assign o_en        = en_q;
  assign o_fault     = fault_q;
  assign o_faultRail = rail_q;
  assign o_busy      = busy_q;
  assign o_allGood   = (state_q == S_ON) && (i_pg == 3'b111);

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with STEP_DELAY=4, PG_TIMEOUT=8.
module tb_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] pg;
  logic [2:0] en;
  logic       all_good;
  logic       fault;
  logic [1:0] fault_rail;
  logic       busy;
  logic [7:0] obs;

  int total  = 0;
  int passed = 0;

  power_sequencer #(.STEP_DELAY(32'd4), .PG_TIMEOUT(32'd8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_pg       (pg),
    .o_en       (en),
    .o_allGood  (all_good),
    .o_fault    (fault),
    .o_faultRail(fault_rail),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // {en[2:0], fault, fault_rail[1:0], busy, all_good}
  assign obs = {en, fault, fault_rail, busy, all_good};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    enable = 1'b0;
    pg     = 3'b000;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bring_up;
    enable = 1'b1;
    tick;
    for (int n = 0; n < 3; n++) begin
      tick;
      pg[n] = 1'b1;
      repeat (5) tick;
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    enable = 1'b0;
    pg     = 3'b000;
    #2;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL reset_state got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL idle_after_release got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
  endtask

  task automatic test_normal_up;
    do_reset;
    enable = 1'b1;
    tick;
    total++;
    if (obs !== 8'b001_0_00_1_0) $display("FAIL up_r0 got %b want %b", obs, 8'b001_0_00_1_0);
    else passed++;
    tick;
    pg = 3'b001;
    repeat (4) tick;
    total++;
    if (obs !== 8'b001_0_00_1_0) $display("FAIL settle0_hold got %b want %b", obs, 8'b001_0_00_1_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL up_r1 got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    tick;
    pg = 3'b011;
    repeat (4) tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL settle1_hold got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b111_0_00_1_0) $display("FAIL up_r2 got %b want %b", obs, 8'b111_0_00_1_0);
    else passed++;
    tick;
    pg = 3'b111;
    repeat (4) tick;
    total++;
    if (obs !== 8'b111_0_00_1_0) $display("FAIL settle2_hold got %b want %b", obs, 8'b111_0_00_1_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b111_0_00_0_1) $display("FAIL on_state got %b want %b", obs, 8'b111_0_00_0_1);
    else passed++;
  endtask

  task automatic test_timeout;
    do_reset;
    enable = 1'b1;
    tick;
    tick;
    pg = 3'b001;
    repeat (5) tick;
    repeat (7) tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL to_pre got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b000_1_01_0_0) $display("FAIL to_fault got %b want %b", obs, 8'b000_1_01_0_0);
    else passed++;
    repeat (3) tick;
    total++;
    if (obs !== 8'b000_1_01_0_0) $display("FAIL to_hold got %b want %b", obs, 8'b000_1_01_0_0);
    else passed++;
    enable = 1'b0;
    tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL to_clear got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
  endtask

  task automatic test_timeout_edge;
    do_reset;
    enable = 1'b1;
    tick;
    tick;
    pg = 3'b001;
    repeat (5) tick;
    repeat (7) tick;
    pg = 3'b011;
    tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL to_edge_pg got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    repeat (4) tick;
    total++;
    if (obs !== 8'b111_0_00_1_0) $display("FAIL to_edge_next got %b want %b", obs, 8'b111_0_00_1_0);
    else passed++;
  endtask

  task automatic test_runtime_fault;
    do_reset;
    bring_up;
    total++;
    if (obs !== 8'b111_0_00_0_1) $display("FAIL rt_on got %b want %b", obs, 8'b111_0_00_0_1);
    else passed++;
    pg = 3'b010;
    #1;
    total++;
    if (obs !== 8'b111_0_00_0_0) $display("FAIL rt_allgood_drop got %b want %b", obs, 8'b111_0_00_0_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b000_1_00_0_0) $display("FAIL rt_fault got %b want %b", obs, 8'b000_1_00_0_0);
    else passed++;
    enable = 1'b0;
    tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL rt_clear got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
  endtask

  task automatic test_shutdown;
    do_reset;
    bring_up;
    enable = 1'b0;
    tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL sd_entry got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    enable = 1'b1;
    pg     = 3'b000;
    repeat (3) tick;
    total++;
    if (obs !== 8'b011_0_00_1_0) $display("FAIL sd_hold2 got %b want %b", obs, 8'b011_0_00_1_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b001_0_00_1_0) $display("FAIL sd_rail1 got %b want %b", obs, 8'b001_0_00_1_0);
    else passed++;
    repeat (4) tick;
    total++;
    if (obs !== 8'b000_0_00_1_0) $display("FAIL sd_rail0 got %b want %b", obs, 8'b000_0_00_1_0);
    else passed++;
    repeat (4) tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL sd_idle got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
    enable = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    logic [7:0] want;
    do_reset;
    enable = 1'b1;
    tick;
    tick;
    pg = 3'b001;
    repeat (5) tick;
    tick;
    enable = 1'b0;
    tick;
    total++;
    if (obs !== 8'b001_0_00_1_0) $display("FAIL ab_entry got %b want %b", obs, 8'b001_0_00_1_0);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      tick;
      want = (i < 4) ? 8'b001_0_00_1_0 : (i < 8) ? 8'b000_0_00_1_0 : 8'b000_0_00_0_0;
      total++;
      if (obs !== want) $display("FAIL ab_step%0d got %b want %b", i, obs, want);
      else passed++;
    end
  endtask

  task automatic test_priority;
    do_reset;
    bring_up;
    pg     = 3'b110;
    enable = 1'b0;
    tick;
    total++;
    if (obs !== 8'b000_1_00_0_0) $display("FAIL pri_fault_over_off got %b want %b", obs, 8'b000_1_00_0_0);
    else passed++;
    tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL pri_exit got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
    do_reset;
    enable = 1'b1;
    tick;
    tick;
    pg = 3'b001;
    repeat (5) tick;
    tick;
    pg = 3'b011;
    tick;
    pg = 3'b010;
    tick;
    total++;
    if (obs !== 8'b000_1_00_0_0) $display("FAIL settle_fault got %b want %b", obs, 8'b000_1_00_0_0);
    else passed++;
  endtask

  task automatic test_async_reset;
    do_reset;
    bring_up;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL async_reset got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    total++;
    if (obs !== 8'b000_0_00_0_0) $display("FAIL post_reset_idle got %b want %b", obs, 8'b000_0_00_0_0);
    else passed++;
    enable = 1'b1;
    pg     = 3'b000;
    tick;
    total++;
    if (obs !== 8'b001_0_00_1_0) $display("FAIL repower got %b want %b", obs, 8'b001_0_00_1_0);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_normal_up;
    test_timeout;
    test_timeout_edge;
    test_runtime_fault;
    test_shutdown;
    test_abort;
    test_priority;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 Parameter STEP_DELAY, default 32'd1000: settle cycles after each rail good, and between rail disables at shutdown; legal range 1..2^32-1.
REQ-002 Parameter PG_TIMEOUT, default 32'd100000: max cycles from rail enable to its power-good; legal range 1..2^32-1.
REQ-003 i_clk  input  1  system clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_enable  input  1  level request: 1 = power up rails, 0 = power down; synchronous to i_clk.
REQ-006 i_pg  input  3  per-rail power-good, bit n = rail n; synchronous to i_clk.
REQ-007 o_en  output  3  per-rail enable, bit n = rail n, registered.
REQ-008 o_allGood  output  1  all rails up and good.
REQ-009 o_fault  output  1  fault latched, registered.
REQ-010 o_faultRail  output  2  index of the failing rail, registered; valid while o_fault=1.
REQ-011 o_busy  output  1  sequencing in progress (RAMP, SETTLE or SHUTDOWN), registered.

Function
REQ-012 States: IDLE, RAMP, SETTLE, ON, SHUTDOWN, FAULT; 2-bit rail index idx; one 32-bit cycle counter cnt.
REQ-013 IDLE: o_en=000; i_enable=1 -> RAMP with idx=0, cnt=0, o_en=001 visible after the same edge.
REQ-014 RAMP: o_en bits 0..idx=1; i_pg[idx]=1 -> SETTLE with cnt=0; otherwise cnt increments.
REQ-015 RAMP timeout: i_pg[idx]=0 while cnt==PG_TIMEOUT-1 -> FAULT with o_faultRail=idx; pg arriving on that same edge wins (SETTLE).
REQ-016 SETTLE: cnt increments; at cnt==STEP_DELAY-1, idx<2 -> idx+1, RAMP, cnt=0, o_en[idx+1]=1; idx==2 -> ON.
REQ-017 In RAMP and SETTLE, any i_pg[k]=0 for k<idx, and in SETTLE for k==idx, -> FAULT with o_faultRail=lowest such k.
REQ-018 ON: o_en=111; any i_pg bit 0 -> FAULT with o_faultRail=lowest failing index; i_enable=0 -> SHUTDOWN, idx=2.
REQ-019 o_allGood is combinational: 1 iff state==ON and i_pg==111; deasserts in the same cycle as any pg drop.
REQ-020 i_enable=0 in RAMP or SETTLE -> SHUTDOWN from current idx; rails above idx are never enabled.
REQ-021 SHUTDOWN: on entry clear o_en[idx], cnt=0; after STEP_DELAY cycles, idx>0 -> idx-1 and clear o_en[idx-1]; idx==0 -> IDLE; i_enable returning to 1 does not abort shutdown.
REQ-022 Shutdown order is strictly rail 2, 1, 0 (descending), STEP_DELAY cycles apart; i_pg ignored during SHUTDOWN.
REQ-023 FAULT: o_en=000 on the entry edge (all rails dropped together), o_fault=1, o_faultRail held.
REQ-024 FAULT exit: only on i_enable=0 sampled -> IDLE, clearing o_fault and o_faultRail=00; holding i_enable=1 never re-powers.
REQ-025 Priority when events coincide on one edge: fault > i_enable=0 > sequence progress.
REQ-026 o_busy=1 exactly in RAMP, SETTLE, SHUTDOWN.
REQ-027 cnt never wraps; it is cleared on every state or idx change.

Reset
REQ-028 i_rst_n=0 immediately forces IDLE, idx=0, cnt=0, o_en=000, o_fault=0, o_faultRail=00, o_busy=0, independent of i_clk.
REQ-029 Reset mid-sequence or in ON drops all enables at once; after release, power-up requires i_enable=1 sampled in IDLE.

Verification (STEP_DELAY=4, PG_TIMEOUT=8)
REQ-030 Normal up: i_enable=1, each pg rises 2 cycles after its enable -> o_en 001,011,111 in order, 4 settle cycles each, o_allGood=1, o_busy=0.
REQ-031 Timeout: i_enable=1, i_pg[1] held 0 -> 8 cycles after o_en[1]=1, o_en=000, o_fault=1, o_faultRail=01; stays until i_enable=0, then IDLE.
REQ-032 Runtime fault: in ON drop i_pg[2] and i_pg[0] together -> o_allGood=0 same cycle, next edge o_en=000, o_faultRail=00.
REQ-033 Shutdown: in ON set i_enable=0 -> o_en 011, 001, 000 at 4-cycle spacing, then IDLE; i_enable=1 mid-shutdown ignored.
REQ-034 Abort: i_enable=0 during rail-1 RAMP -> o_en 001, after 4 cycles 000, IDLE; o_en[2] never set.
REQ-035 Async reset: assert i_rst_n=0 between clock edges while in ON -> o_en=000, o_allGood=0 before next edge.
